adc_sample_feeder: RTL

Front-end producer of ADC samples for the center/scale datapath. Deserializes a framed, MSB-first serial ADC stream into 21-bit sample words, buffers them in a small FIFO, and issues them as `x_adc` plus a one-cycle `srdyo_o` strobe. Successive strobes are spaced at least `MIN_GAP` cycles apart so the downstream latch-and-pipeline stage is never overrun. Sits between the ADC pins (already synchronized to `clk`) and the centering/scaling block's `x_adc`/`srdyi` inputs.

---
 rtl/adc_sample_feeder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/adc_sample_feeder.sv
// adc_sample_feeder: deserializes a framed MSB-first serial ADC stream into
// DATA_W-bit words, buffers them, and issues them with a minimum strobe spacing.
module adc_sample_feeder #(
    parameter int DATA_W  = 21,
    parameter int MIN_GAP = 18,
    parameter int DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   GlobalReset,
    input  logic                   adc_sdata,
    input  logic                   adc_frame,
    input  logic                   enable,
    input  logic                   clear_i,
    output logic [DATA_W-1:0]      x_adc,
    output logic                   srdyo_o,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow_o,
    output logic                   frame_err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = $clog2(MIN_GAP + 1);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAIL  = 2'd2
    } state_t;

    state_t              state_r;
    logic [DATA_W-1:0]   shift_r;
    logic [BIT_W-1:0]    bit_cnt_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [GAP_W-1:0]    gap_r;

    logic                push_s;
    logic                err_set_s;
    logic [DATA_W-1:0]   word_s;
    logic                full_s;
    logic                pop_s;
    logic                drop_s;
    logic                write_s;

    // Frame decode: word completion on the last bit and framing-error detection
    always_comb begin
        push_s    = 1'b0;
        err_set_s = 1'b0;
        word_s    = {shift_r[DATA_W-2:0], adc_sdata};
        case (state_r)
            ST_SHIFT: begin
                if (!adc_frame) begin
                    err_set_s = 1'b1;
                end else if (bit_cnt_r == LAST_BIT) begin
                    push_s = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
            end
            ST_TAIL: begin
                err_set_s = adc_frame;
            end
            default: begin
                push_s    = 1'b0;
                err_set_s = 1'b0;
            end
        endcase
    end

    // Issue and FIFO arbitration; a pop frees a slot for a same-cycle push
    always_comb begin
        full_s  = (fifo_count == FULL_CNT);
        pop_s   = (fifo_count != {CNT_W{1'b0}}) && enable && (gap_r == {GAP_W{1'b0}});
        drop_s  = push_s && full_s && !pop_s;
        write_s = push_s && !drop_s;
    end

    // Deserializer FSM; the first bit enters at the LSB and ends up at the MSB
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state_r   <= ST_IDLE;
            shift_r   <= {DATA_W{1'b0}};
            bit_cnt_r <= {BIT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (adc_frame) begin
                        shift_r   <= {{(DATA_W-1){1'b0}}, adc_sdata};
                        bit_cnt_r <= BIT_W'(1);
                        state_r   <= ST_SHIFT;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (!adc_frame) begin
                        state_r <= ST_IDLE;
                    end else if (push_s) begin
                        state_r <= ST_TAIL;
                    end else begin
                        shift_r   <= word_s;
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    end
                end
                ST_TAIL: begin
                    if (!adc_frame) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_TAIL;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_count <= {CNT_W{1'b0}};
        end else begin
            if (write_s) begin
                mem_r[wr_ptr_r] <= word_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({write_s, pop_s})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Issue stage: registered sample/strobe and the strobe-spacing counter
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            x_adc   <= {DATA_W{1'b0}};
            srdyo_o <= 1'b0;
            gap_r   <= {GAP_W{1'b0}};
        end else begin
            srdyo_o <= pop_s;
            if (pop_s) begin
                x_adc <= mem_r[rd_ptr_r];
                gap_r <= GAP_LOAD;
            end else if (gap_r != {GAP_W{1'b0}}) begin
                gap_r <= gap_r - GAP_W'(1);
            end else begin
                gap_r <= gap_r;
            end
        end
    end

    // Sticky flags; a set event wins over a simultaneous clear
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            overflow_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            overflow_o  <= drop_s    | (overflow_o  & ~clear_i);
            frame_err_o <= err_set_s | (frame_err_o & ~clear_i);
        end
    end

endmodule
